// File: rtl/inst_prefetch_buf_pkg.sv
// inst_prefetch_buf_pkg: shared bus widths, prefetch FSM states and FIFO entry type
package inst_prefetch_buf_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  typedef enum logic [1:0] {PF_IDLE = 2'd0, PF_REQ = 2'd1, PF_DRAIN = 2'd2} pf_state_e;
  typedef struct packed {
    logic [INST_ADDR_W-1:0] addr;
    logic [INST_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/inst_prefetch_buf_if.sv
// inst_prefetch_buf_if: core fetch port and memory req/ack bus; PREFETCH_STATS_EN adds counters
interface inst_prefetch_buf_if;
  logic core_ce_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_inst_o;
  logic stall_req_o;
  logic mem_req_o;
  logic [31:0] mem_addr_o;
  logic mem_ack_i;
  logic [31:0] mem_rdata_i;
`ifdef PREFETCH_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif
  modport slave (
    input core_ce_i, core_addr_i, mem_ack_i, mem_rdata_i,
`ifdef PREFETCH_STATS_EN
    output hit_cnt_o, miss_cnt_o,
`endif
    output core_inst_o, stall_req_o, mem_req_o, mem_addr_o
  );
  modport master (
    output core_ce_i, core_addr_i, mem_ack_i, mem_rdata_i,
`ifdef PREFETCH_STATS_EN
    input hit_cnt_o, miss_cnt_o,
`endif
    input core_inst_o, stall_req_o, mem_req_o, mem_addr_o
  );
endinterface

// File: rtl/inst_prefetch_buf_fifo.sv
// inst_fifo: DEPTH-entry {addr,data} synchronous FIFO; flush overrides push
module inst_fifo
  import inst_prefetch_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr, rd;
  logic [PTR_W:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (PTR_W+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !flush && (!full || pop);
  assign do_pop = pop && !empty;
  assign head = mem[rd];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/inst_prefetch_buf.sv
// inst_prefetch_buf: sequential instruction prefetcher in front of a req/ack memory.
// Optional PREFETCH_STATS_EN adds saturating hit/miss counters on the interface.
module inst_prefetch_buf
  import inst_prefetch_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic clk,
  input logic rst,
  inst_prefetch_buf_if.slave bus
);
  pf_state_e state, state_nx;
  logic [31:0] next_addr, mem_addr, tgt_addr;
  fetch_entry_t head;
  logic full, empty, hit, miss, redirect, push, issue;
  assign hit = bus.core_ce_i && !empty && head.addr == bus.core_addr_i;
  assign miss = bus.core_ce_i && !hit;
  // Any miss not explained by the word already in flight restarts the stream at the core PC.
  assign redirect = miss && (!empty || next_addr != bus.core_addr_i);
  assign tgt_addr = redirect ? bus.core_addr_i : next_addr;
  assign bus.core_inst_o = hit ? head.data : ZERO_WORD;
  assign bus.stall_req_o = miss;
  assign bus.mem_req_o = state != PF_IDLE;
  assign bus.mem_addr_o = mem_addr;
  always_comb begin
    issue = state == PF_IDLE && bus.core_ce_i && (redirect || hit || !full);
    push = state == PF_REQ && bus.mem_ack_i && bus.core_ce_i && !redirect;
    state_nx = issue ? PF_REQ
             : (state != PF_IDLE && bus.mem_ack_i) ? PF_IDLE
             : (state == PF_REQ && redirect) ? PF_DRAIN
             : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= PF_IDLE;
      next_addr <= '0;
      mem_addr <= '0;
    end else begin
      state <= state_nx;
      next_addr <= push ? next_addr + 32'd4 : tgt_addr;
      if (issue) mem_addr <= tgt_addr;
    end
  inst_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(hit),
    .flush(redirect),
    .din({mem_addr, bus.mem_rdata_i}),
    .full(full),
    .empty(empty),
    .head(head)
  );
`ifdef PREFETCH_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (miss && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  assign bus.hit_cnt_o = hit_cnt;
  assign bus.miss_cnt_o = miss_cnt;
`endif
endmodule

// File: tb/tb_inst_prefetch_buf.sv
// tb_inst_prefetch_buf: vector table, corner sequences and randomized run against a queue model
module tb_inst_prefetch_buf;
  import inst_prefetch_buf_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  inst_prefetch_buf_if bus();
  inst_prefetch_buf #(.DEPTH(DEPTH), .PTR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic f_push, f_pop, f_flush, f_full, f_empty;
  fetch_entry_t f_din, f_head;
  inst_fifo #(.DEPTH(DEPTH), .PTR_W(2)) fb (
    .clk(clk), .rst(rst), .push(f_push), .pop(f_pop), .flush(f_flush),
    .din(f_din), .full(f_full), .empty(f_empty), .head(f_head)
  );
  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic ce; logic [31:0] addr; logic ack; logic [31:0] rdata;
    logic stall; logic [31:0] inst; logic req; logic [31:0] maddr;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic ce, input logic [31:0] addr, input logic ack, input logic [31:0] rdata,
                     input logic stall, input logic [31:0] inst, input logic req, input logic [31:0] maddr);
    tv.push_back('{ce, addr, ack, rdata, stall, inst, req, maddr});
  endtask
  typedef struct packed {logic [31:0] a; logic [31:0] d;} ent_t;
  ent_t q[$];
  bit m_busy, m_keep;
  logic [31:0] m_next, m_raddr;
  int m_hits, m_miss;
  task automatic model_reset();
    q.delete();
    m_busy = 0; m_keep = 0; m_next = '0; m_raddr = '0; m_hits = 0; m_miss = 0;
  endtask
  // One fetch cycle: outputs from the current state, then the state after the clock edge.
  task automatic model_cycle(input logic ce, input logic [31:0] a, input logic ack, input logic [31:0] rd,
                             output logic e_stall, output logic [31:0] e_inst,
                             output logic e_req, output logic [31:0] e_maddr, output logic e_hit);
    logic h, redir;
    h = ce && q.size() > 0 && q[0].a == a;
    redir = ce && !h && (q.size() > 0 || m_next != a);
    e_hit = h; e_stall = ce && !h; e_inst = h ? q[0].d : 32'h0; e_req = m_busy; e_maddr = m_raddr;
    if (h) begin m_hits++; void'(q.pop_front()); end
    if (ce && !h) m_miss++;
    if (redir) begin q.delete(); m_next = a; end
    if (m_busy) begin
      if (redir) m_keep = 0;
      if (ack) begin
        m_busy = 0;
        if (m_keep && ce) begin q.push_back('{a: m_raddr, d: rd}); m_next = m_next + 32'd4; end
      end
    end else if (ce && q.size() < DEPTH) begin
      m_busy = 1; m_keep = 1; m_raddr = m_next;
    end
  endtask
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction
  logic e_stall, e_req, e_hit, last_hit;
  logic [31:0] e_inst, e_maddr, c_addr;
  int lat;
  initial begin
    bus.core_ce_i = 0; bus.core_addr_i = 0; bus.mem_ack_i = 0; bus.mem_rdata_i = 0;
    f_push = 0; f_pop = 0; f_flush = 0; f_din = '0;
    add(0, 32'h00, 0, 32'h0,    0, 32'h0,   0, 32'h00);
    add(1, 32'h00, 0, 32'h0,    1, 32'h0,   0, 32'h00);
    add(1, 32'h00, 1, 32'h100,  1, 32'h0,   1, 32'h00);
    add(1, 32'h00, 0, 32'h0,    0, 32'h100, 0, 32'h00);
    for (int i = 0; i < 4; i++) add(1, 32'h04, 0, 32'h0, 1, 32'h0, 1, 32'h04);
    add(1, 32'h04, 1, 32'h104, 1, 32'h0,   1, 32'h04);
    add(1, 32'h04, 0, 32'h0,   0, 32'h104, 0, 32'h04);
    add(1, 32'h08, 1, 32'h108, 1, 32'h0,   1, 32'h08);
    add(1, 32'h08, 0, 32'h0,   0, 32'h108, 0, 32'h08);
    add(1, 32'h80, 0, 32'h0,   1, 32'h0,   1, 32'h0c);
    add(1, 32'h80, 1, 32'hdead,1, 32'h0,   1, 32'h0c);
    add(1, 32'h80, 0, 32'h0,   1, 32'h0,   0, 32'h0c);
    add(1, 32'h80, 1, 32'h180, 1, 32'h0,   1, 32'h80);
    add(1, 32'h80, 0, 32'h0,   0, 32'h180, 0, 32'h80);
    add(0, 32'h84, 1, 32'h184, 0, 32'h0,   1, 32'h84);
    add(0, 32'h84, 0, 32'h0,   0, 32'h0,   0, 32'h84);
    add(1, 32'h84, 0, 32'h0,   1, 32'h0,   0, 32'h84);
    add(1, 32'h84, 1, 32'h184, 1, 32'h0,   1, 32'h84);
    add(1, 32'h84, 0, 32'h0,   0, 32'h184, 0, 32'h84);
    add(1, 32'h200,1, 32'hbeef,1, 32'h0,   1, 32'h88);
    add(1, 32'h200,0, 32'h0,   1, 32'h0,   0, 32'h88);
    add(1, 32'h200,1, 32'h300, 1, 32'h0,   1, 32'h200);
    add(1, 32'h200,0, 32'h0,   0, 32'h300, 0, 32'h200);
    add(1, 32'h204,1, 32'h304, 1, 32'h0,   1, 32'h204);
    add(1, 32'h40, 0, 32'h0,   1, 32'h0,   0, 32'h204);
    add(1, 32'h40, 1, 32'h140, 1, 32'h0,   1, 32'h40);
    add(1, 32'h40, 0, 32'h0,   0, 32'h140, 0, 32'h40);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    foreach (tv[i]) begin
      @(posedge clk); #1;
      bus.core_ce_i = tv[i].ce; bus.core_addr_i = tv[i].addr;
      bus.mem_ack_i = tv[i].ack; bus.mem_rdata_i = tv[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), bus.stall_req_o, tv[i].stall);
      chk($sformatf("vec%0d inst", i), bus.core_inst_o, tv[i].inst);
      chk($sformatf("vec%0d req", i), bus.mem_req_o, tv[i].req);
      chk($sformatf("vec%0d maddr", i), bus.mem_addr_o, tv[i].maddr);
    end
`ifdef PREFETCH_STATS_EN
    chk("tbl hit_cnt", bus.hit_cnt_o, 32'd7);
    chk("tbl miss_cnt", bus.miss_cnt_o, 32'd20);
`endif
    // Asynchronous reset while a request for 0x44 is outstanding.
    @(posedge clk); #1;
    bus.core_ce_i = 0; bus.mem_ack_i = 0;
    @(negedge clk);
    chk("pre-rst req", bus.mem_req_o, 1'b1);
    chk("pre-rst maddr", bus.mem_addr_o, 32'h44);
    #1 rst = 1;
    #1;
    chk("async rst req", bus.mem_req_o, 1'b0);
    chk("async rst maddr", bus.mem_addr_o, 32'h0);
    chk("async rst stall", bus.stall_req_o, 1'b0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    bus.core_ce_i = 1; bus.core_addr_i = 32'h44;
    @(negedge clk);
    chk("post-rst stall", bus.stall_req_o, 1'b1);
    chk("post-rst inst", bus.core_inst_o, 32'h0);
    chk("post-rst req", bus.mem_req_o, 1'b0);
    bus.core_ce_i = 0;
    // FIFO fill to DEPTH, push+pop at full, ordered drain, flush over push.
    chk("fifo empty", f_empty, 1'b1);
    chk("fifo not full", f_full, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      f_push = 1; f_din = '{addr: 32'(4 * k + 4), data: 32'(32'ha0 + k)};
      @(posedge clk); #1 f_push = 0;
      @(negedge clk);
    end
    chk("fifo full", f_full, 1'b1);
    chk("fifo head0", f_head.addr, 32'h4);
    f_push = 1; f_pop = 1; f_din = '{addr: 32'h14, data: 32'ha4};
    @(posedge clk); #1 f_push = 0; f_pop = 0;
    @(negedge clk);
    chk("fifo full after push+pop", f_full, 1'b1);
    chk("fifo head after push+pop", f_head.addr, 32'h8);
    chk("fifo head data", f_head.data, 32'ha1);
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("fifo order%0d", k), f_head.addr, 32'(4 * k + 8));
      f_pop = 1;
      @(posedge clk); #1 f_pop = 0;
      @(negedge clk);
    end
    chk("fifo drained", f_empty, 1'b1);
    f_push = 1; f_flush = 1; f_din = '{addr: 32'h20, data: 32'h1};
    @(posedge clk); #1 f_push = 0; f_flush = 0;
    @(negedge clk);
    chk("fifo flush over push", f_empty, 1'b1);
    // Randomized run: core follows stalls/hits with occasional jumps, memory acks after 0..3 cycles.
    rst = 1;
    @(negedge clk) rst = 0;
    model_reset();
    c_addr = 0; last_hit = 0; lat = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (last_hit) c_addr = c_addr + 32'd4;
      if ($urandom_range(0, 15) == 0)
        c_addr = ($urandom_range(0, 1) == 1 ? 32'hffff_fff0 : 32'h0) + 32'(4 * $urandom_range(0, 15));
      bus.core_ce_i = $urandom_range(0, 7) != 0;
      bus.core_addr_i = c_addr;
      bus.mem_ack_i = 0;
      bus.mem_rdata_i = $urandom;
      if (m_busy) begin
        if (lat == 0) begin
          bus.mem_ack_i = 1; bus.mem_rdata_i = data_of(m_raddr); lat = $urandom_range(0, 3);
        end else lat--;
      end
      @(negedge clk);
      model_cycle(bus.core_ce_i, bus.core_addr_i, bus.mem_ack_i, bus.mem_rdata_i,
                  e_stall, e_inst, e_req, e_maddr, e_hit);
      chk($sformatf("rnd%0d stall", c), bus.stall_req_o, e_stall);
      chk($sformatf("rnd%0d inst", c), bus.core_inst_o, e_inst);
      chk($sformatf("rnd%0d req", c), bus.mem_req_o, e_req);
      chk($sformatf("rnd%0d maddr", c), bus.mem_addr_o, e_maddr);
      last_hit = e_hit;
    end
`ifdef PREFETCH_STATS_EN
    chk("rnd hit_cnt", bus.hit_cnt_o, 32'(m_hits));
    chk("rnd miss_cnt", bus.miss_cnt_o, 32'(m_miss));
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
